prio_fifo: RTL and testbench
============================

PRIO_FIFO -- requirements
Module: prio_fifo

Interface
REQ-001 Parameter ADDR_WIDTH, default 5; capacity DEPTH = 2**ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 183; entry width.
REQ-003 Parameter LABEL_WIDTH, default 16; priority label = din[DATA_WIDTH-1 -: LABEL_WIDTH].
REQ-004 Parameter CLEAR_ON_INIT, default 1; 1 = storage zeroed on reset.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  one clock; reset is synchronous and active-low.
REQ-007 re  input  1  pop request, one-cycle pulse.
REQ-008 we  input  1  push request, one-cycle pulse.
REQ-009 din  input  DATA_WIDTH  entry to push.
REQ-010 dout  output  DATA_WIDTH  last popped entry, registered.
REQ-011 valid  output  1  one-cycle pulse: dout updated by a pop.
REQ-012 empty  output  1  no entries stored, registered.
REQ-013 full  output  1  DEPTH entries stored, registered.

Function
REQ-014 Order: pop returns the stored entry with the smallest unsigned label (earliest deadline); among equal labels, the earliest pushed.
REQ-015 Storage kept sorted: push inserts at the first slot whose label is strictly greater than the new label, shifting later slots down one; pop removes slot 0 and shifts all slots up one.
REQ-016 Push latency: entry is visible to a pop issued the next cycle.
REQ-017 Pop latency: re sampled at edge N -> dout = popped entry and valid = 1 after edge N; valid = 0 after edge N+1.
REQ-018 dout holds its value until the next successful pop.
REQ-019 Pop while empty: ignored; valid stays 0; dout unchanged.
REQ-020 Push while full and re = 0: ignored; contents unchanged.
REQ-021 re and we in the same cycle: both evaluated against pre-edge state; pop removes the old head and the new entry is inserted among the remainder; count unchanged; legal when full.
REQ-022 re and we in the same cycle while empty: push accepted, pop ignored, valid = 0.
REQ-023 Count range 0..DEPTH, width ADDR_WIDTH+1; empty = (count == 0); full = (count == DEPTH); both reflect the state after each edge.
REQ-024 Label compare is plain unsigned; no deadline wrap handling.

Reset
REQ-025 On rst = 0 at a clock edge: count = 0, empty = 1, full = 0, valid = 0, dout = 0.
REQ-026 CLEAR_ON_INIT = 1: every storage slot zeroed; CLEAR_ON_INIT = 0: slot contents unspecified, treated as invalid.
REQ-027 Reset has priority over re/we in the same cycle; reset mid-operation discards all entries.

Configuration
REQ-028 Macro PRIO_FIFO_COUNT_EN defined: extra output data_count [ADDR_WIDTH:0] equals the registered count.
REQ-029 Macro PRIO_FIFO_COUNT_EN undefined: port data_count absent; all other behaviour identical.

Structure
REQ-030 Package prio_fifo_pkg holds default ADDR_WIDTH, DATA_WIDTH and LABEL_WIDTH constants, plus a label-extract helper.
REQ-031 One sub-module, prio_fifo_slot: a single sorted cell holding entry plus occupied flag, with insert/shift-up/shift-down control; generated DEPTH times.

Verification
REQ-032 Push labels 0x0030, 0x0010, 0x0020, then 3 pops -> valid pulses with labels 0x0010, 0x0020, 0x0030; empty = 1 after the third pop.
REQ-033 Push A (label 0x0005, payload 1) then B (label 0x0005, payload 2); pop twice -> payload 1 then payload 2.
REQ-034 Push 32 entries -> full = 1; 33rd push with label 0x0000 ignored; 32 pops return the original 32 in order.
REQ-035 Full FIFO; re and we together with label 0x0000 -> full stays 1; the next pop returns the label-0x0000 entry.
REQ-036 re on empty -> valid = 0, dout unchanged; re and we together on empty -> empty = 0 next cycle, valid = 0.
REQ-037 5 entries stored, rst = 0 for one cycle -> empty = 1, full = 0, dout = 0, valid = 0; a following pop yields no valid.

Source files
------------

// File: rtl/prio_fifo_pkg.sv
// Shared constants, slot opcodes and label extraction for the priority FIFO.
package prio_fifo_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 5;
    localparam int unsigned DEF_DATA_WIDTH  = 183;
    localparam int unsigned DEF_LABEL_WIDTH = 16;
    localparam int unsigned MAX_DATA_WIDTH  = 1024;
    localparam int unsigned MAX_LABEL_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } slot_op_e;

    // Label is the top label_w bits of the entry, zero-extended for unsigned compare.
    function automatic logic [MAX_LABEL_WIDTH-1:0] label_of(
        input logic [MAX_DATA_WIDTH-1:0] data,
        input int unsigned               data_w,
        input int unsigned               label_w
    );
        logic [MAX_DATA_WIDTH-1:0]  shifted;
        logic [MAX_LABEL_WIDTH-1:0] mask;
        shifted = data >> (data_w - label_w);
        mask    = ~(~MAX_LABEL_WIDTH'(0) << label_w);
        return MAX_LABEL_WIDTH'(shifted) & mask;
    endfunction

endpackage

// File: rtl/prio_fifo_if.sv
// Push/pop handshake bundle of the priority FIFO.
interface prio_fifo_if
    import prio_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();
    logic                  re;
    logic                  we;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  empty;
    logic                  full;

    modport master (output re, we, din, input dout, valid, empty, full);
    modport slave  (input re, we, din, output dout, valid, empty, full);
endinterface

// File: rtl/prio_fifo_slot.sv
// One cell of the sorted storage array: entry plus occupied flag, fed by its neighbours.
module prio_fifo_slot
    import prio_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned LABEL_WIDTH   = DEF_LABEL_WIDTH,
    parameter bit          CLEAR_ON_INIT = 1'b1,
    parameter bit          IS_HEAD       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  slot_op_e              op_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  prev_after_i,
    input  logic                  prev_occ_i,
    input  logic [DATA_WIDTH-1:0] prev_data_i,
    input  logic                  next_after_i,
    input  logic                  next_occ_i,
    input  logic [DATA_WIDTH-1:0] next_data_i,
    output logic                  after_o_c,
    output logic                  occ_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic                       occ_q, occ_d;
    logic [MAX_LABEL_WIDTH-1:0] own_label, new_label;

    assign own_label = label_of(MAX_DATA_WIDTH'(data_q), DATA_WIDTH, LABEL_WIDTH);
    assign new_label = label_of(MAX_DATA_WIDTH'(din_i), DATA_WIDTH, LABEL_WIDTH);

    // Set when this slot sits at or past the insertion point of din_i.
    assign after_o_c = !occ_q || (own_label > new_label);

    assign occ_o  = occ_q;
    assign data_o = data_q;

    always_comb begin
        data_d = data_q;
        occ_d  = occ_q;
        case (op_i)
            OP_PUSH: begin
                if (after_o_c) begin
                    if (prev_after_i) begin
                        data_d = prev_data_i;
                        occ_d  = prev_occ_i;
                    end else begin
                        data_d = din_i;
                        occ_d  = 1'b1;
                    end
                end
            end
            OP_POP: begin
                data_d = next_data_i;
                occ_d  = next_occ_i;
            end
            // Head leaves; slots before the insertion point move up, the new entry fills the gap.
            OP_REPL: begin
                if (IS_HEAD || !after_o_c) begin
                    data_d = next_after_i ? din_i : next_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q <= 1'b0;
            if (CLEAR_ON_INIT) begin
                data_q <= '0;
            end
        end else begin
            occ_q  <= occ_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/prio_fifo.sv
// Priority FIFO: pops the smallest label first, FIFO among equal labels.
// Define PRIO_FIFO_COUNT_EN to expose the registered entry count on data_count.
module prio_fifo
    import prio_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned LABEL_WIDTH   = DEF_LABEL_WIDTH,
    parameter bit          CLEAR_ON_INIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    prio_fifo_if.slave       bus
`ifdef PRIO_FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0] data_count
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, full_q, valid_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  do_pop_c, do_push_c;
    slot_op_e              op_c;

    logic [DATA_WIDTH-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0]      slot_occ;
    logic [DEPTH-1:0]      slot_after;

    // A simultaneous pop frees a slot, so push is accepted when full if a pop goes with it.
    always_comb begin
        do_pop_c  = bus.re && !empty_q;
        do_push_c = bus.we && (!full_q || do_pop_c);
        op_c      = OP_HOLD;
        if (do_pop_c && do_push_c) begin
            op_c = OP_REPL;
        end else if (do_pop_c) begin
            op_c = OP_POP;
        end else if (do_push_c) begin
            op_c = OP_PUSH;
        end
        count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
            valid_q <= do_pop_c;
            if (do_pop_c) begin
                dout_q <= slot_data[0];
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic                  prev_after, prev_occ, next_after, next_occ;
        logic [DATA_WIDTH-1:0] prev_data, next_data;

        if (i == 0) begin : g_first
            assign prev_after = 1'b0;
            assign prev_occ   = 1'b0;
            assign prev_data  = '0;
        end else begin : g_prev
            assign prev_after = slot_after[i-1];
            assign prev_occ   = slot_occ[i-1];
            assign prev_data  = slot_data[i-1];
        end

        if (i == DEPTH - 1) begin : g_last
            assign next_after = 1'b1;
            assign next_occ   = 1'b0;
            assign next_data  = '0;
        end else begin : g_next
            assign next_after = slot_after[i+1];
            assign next_occ   = slot_occ[i+1];
            assign next_data  = slot_data[i+1];
        end

        prio_fifo_slot #(
            .DATA_WIDTH   (DATA_WIDTH),
            .LABEL_WIDTH  (LABEL_WIDTH),
            .CLEAR_ON_INIT(CLEAR_ON_INIT),
            .IS_HEAD      (1'(i == 0))
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .op_i        (op_c),
            .din_i       (bus.din),
            .prev_after_i(prev_after),
            .prev_occ_i  (prev_occ),
            .prev_data_i (prev_data),
            .next_after_i(next_after),
            .next_occ_i  (next_occ),
            .next_data_i (next_data),
            .after_o_c   (slot_after[i]),
            .occ_o       (slot_occ[i]),
            .data_o      (slot_data[i])
        );
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
    assign bus.empty = empty_q;
    assign bus.full  = full_q;

`ifdef PRIO_FIFO_COUNT_EN
    assign data_count = count_q;
`endif

endmodule

// File: tb/tb_prio_fifo.sv
// Self-checking bench for prio_fifo: vector table, corner sequences and a random scoreboard run.
module tb_prio_fifo;
    import prio_fifo_pkg::*;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 183;
    localparam int unsigned LW    = 16;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned PW    = DW - LW;
    localparam int          NV    = 13;

    typedef logic [DW-1:0] entry_t;

    typedef struct {
        logic        re;
        logic        we;
        logic [15:0] lbl;
        logic [15:0] pay;
        logic        exp_valid;
        logic [15:0] exp_lbl;
        logic [15:0] exp_pay;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    logic clk;
    logic rst;
`ifdef PRIO_FIFO_COUNT_EN
    logic [AW:0] data_count;
`endif

    prio_fifo_if #(.DATA_WIDTH(DW)) bus ();

    prio_fifo #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .LABEL_WIDTH  (LW),
        .CLEAR_ON_INIT(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PRIO_FIFO_COUNT_EN
        ,
        .data_count(data_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    entry_t model[$];
    entry_t exp_q[$];
    entry_t last_dout;
    int     checks;
    int     failures;
    vec_t   tbl[NV];

    function automatic entry_t mk(input logic [15:0] lbl, input logic [15:0] pay);
        return {lbl, PW'(pay)};
    endfunction

    task automatic chk(input string name, input entry_t act, input entry_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference order: new entry goes behind every stored entry whose label is <= its own.
    task automatic model_push(input entry_t d);
        int pos;
        pos = model.size();
        for (int k = 0; k < model.size(); k++) begin
            if (model[k][DW-1 -: LW] > d[DW-1 -: LW]) begin
                pos = k;
                break;
            end
        end
        model.insert(pos, d);
    endtask

    task automatic step(input logic r, input logic w, input entry_t d);
        bit     pop_ok, push_ok;
        entry_t e;
        bus.re  = r;
        bus.we  = w;
        bus.din = d;
        pop_ok  = r && (model.size() != 0);
        push_ok = w && ((model.size() < DEPTH) || pop_ok);
        if (pop_ok) exp_q.push_back(model.pop_front());
        if (push_ok) model_push(d);
        @(posedge clk);
        #1;
        bus.re = 1'b0;
        bus.we = 1'b0;
        chk("valid", entry_t'(bus.valid), entry_t'(pop_ok));
        if (bus.valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got dout %h expected no pop", bus.dout);
            end else begin
                e = exp_q.pop_front();
                last_dout = e;
                chk("dout_pop", bus.dout, e);
            end
        end else begin
            chk("dout_hold", bus.dout, last_dout);
        end
        chk("empty", entry_t'(bus.empty), entry_t'(model.size() == 0));
        chk("full", entry_t'(bus.full), entry_t'(model.size() == DEPTH));
`ifdef PRIO_FIFO_COUNT_EN
        chk("data_count", entry_t'(data_count), entry_t'(model.size()));
`endif
    endtask

    // Reset is held for one edge with re/we asserted to show it takes priority.
    task automatic do_reset();
        rst     = 1'b0;
        bus.re  = 1'b1;
        bus.we  = 1'b1;
        bus.din = mk(16'h0001, 16'h0001);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        bus.re = 1'b0;
        bus.we = 1'b0;
        chk("pending_before_reset", entry_t'(exp_q.size()), '0);
        model.delete();
        exp_q.delete();
        last_dout = '0;
        chk("rst_valid", entry_t'(bus.valid), '0);
        chk("rst_empty", entry_t'(bus.empty), entry_t'(1));
        chk("rst_full", entry_t'(bus.full), '0);
        chk("rst_dout", bus.dout, '0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        last_dout = '0;
        rst       = 1'b0;
        bus.re    = 1'b0;
        bus.we    = 1'b0;
        bus.din   = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        //          re    we    lbl       pay       v     exp_lbl   exp_pay   empty full
        tbl[0]  = '{1'b0, 1'b1, 16'h0030, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'h0010, 16'h0002, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'h0020, 16'h0003, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 16'h0002, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0020, 16'h0003, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0030, 16'h0001, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 16'h0005, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 16'h0005, 16'h0002, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0005, 16'h0001, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0005, 16'h0002, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 16'h0007, 16'h0009, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0007, 16'h0009, 1'b1, 1'b0};

        for (int k = 0; k < NV; k++) begin
            step(tbl[k].re, tbl[k].we, mk(tbl[k].lbl, tbl[k].pay));
            chk($sformatf("vec%0d_valid", k), entry_t'(bus.valid), entry_t'(tbl[k].exp_valid));
            if (tbl[k].exp_valid)
                chk($sformatf("vec%0d_dout", k), bus.dout, mk(tbl[k].exp_lbl, tbl[k].exp_pay));
            chk($sformatf("vec%0d_empty", k), entry_t'(bus.empty), entry_t'(tbl[k].exp_empty));
            chk($sformatf("vec%0d_full", k), entry_t'(bus.full), entry_t'(tbl[k].exp_full));
        end

        // Fill with tied labels, reject a push while full, drain in order.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, mk(16'(((i * 7) % 10) + 1), 16'(i)));
        chk("fill_full", entry_t'(bus.full), entry_t'(1));
        step(1'b0, 1'b1, mk(16'h0000, 16'hDEAD));
        chk("overflow_full", entry_t'(bus.full), entry_t'(1));
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0);
        chk("drain_empty", entry_t'(bus.empty), entry_t'(1));

        // Simultaneous pop and push while full.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, mk(16'(i + 1), 16'(i)));
        step(1'b1, 1'b1, mk(16'h0000, 16'h00AB));
        chk("repl_full", entry_t'(bus.full), entry_t'(1));
        chk("repl_old_head", bus.dout, mk(16'h0001, 16'h0000));
        step(1'b1, 1'b0, '0);
        chk("repl_new_head", bus.dout, mk(16'h0000, 16'h00AB));
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, '0);

        // Reset with entries stored, then pop finds nothing.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, mk(16'(40 - i), 16'(i + 3)));
        step(1'b1, 1'b0, '0);
        do_reset();
        step(1'b1, 1'b0, '0);
        chk("post_reset_pop_valid", entry_t'(bus.valid), '0);

        // Random traffic: push-heavy phase then pop-heavy phase.
        for (int i = 0; i < 300; i++) begin
            logic r, w;
            if (i < 150) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step(r, w, mk(16'($urandom_range(0, 15)), 16'($urandom_range(0, 65535))));
        end
        while (model.size() != 0) step(1'b1, 1'b0, '0);
        chk("scoreboard_drained", entry_t'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
